uart_tx_arb: RTL and testbench

Round-robin arbiter that shares one UART byte transmitter among `NUM_REQ` requesters (host register port, debug echo, status reporter, etc.). It accepts one byte at a time from the winning requester and issues a single-cycle start to the transmitter. It holds the transmitter until that frame completes, then re-arbitrates. It sits between the requesters and the baud-driven transmitter and does not touch the baud ticks itself.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_arb_rr_pick.sv | 39 +++
 rtl/uart_tx_arb.sv | 148 ++++++++++++++
 tb/tb_uart_tx_arb.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Purpose: shared types and constants for the UART transmit arbiter and its neighbours.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: arbiter state enum, index-width helper, baud constants used by the transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam int CLK_FREQ  = 10_000_000;
    localparam int BAUD_RATE = 9_600;

    // Width needed to index n items. Never returns zero, so a 1-bit field remains legal.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Purpose: rotating-priority pick of the first valid requester at or after ptr, with wrap.
// Latency: combinational.
// Backpressure: none; the caller gates the result.
//
// Ports: req_valid (per-requester pending), ptr (search start),
//        gnt_oh (one-hot winner), gnt_idx (winner index), any (some requester valid).
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    int          pos;
    logic [IDX_W-1:0] pos_s;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        any     = 1'b0;
        pos     = 0;
        pos_s   = '0;
        // Walk ptr, ptr+1, ... with wrap; the first hit wins and later hits are masked by any.
        for (int k = 0; k < NUM_REQ; k++) begin
            pos   = (int'(ptr) + k) % NUM_REQ;
            pos_s = IDX_W'(pos);
            if (!any && req_valid[pos_s]) begin
                any           = 1'b1;
                gnt_idx       = pos_s;
                gnt_oh[pos_s] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Purpose: round-robin share of one UART byte transmitter among NUM_REQ requesters.
// Latency: accept at T, tx_start at T+1; re-arbitrates the cycle after tx_busy is seen low.
// Backpressure: req_ready is offered only in IDLE; the arbiter holds the transmitter until the frame ends.
//
// Ports: clk, rst_n (async active-low); req_valid/req_data/req_ready (requester side);
//        tx_start/tx_data/tx_busy (transmitter side); grant_id, active, err_timeout (status).
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = 8,
    parameter int START_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        tx_start,
    output logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_busy,
    output logic [idx_w(NUM_REQ)-1:0]   grant_id,
    output logic                        active,
    output logic                        err_timeout
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int CNT_W = idx_w(START_TIMEOUT);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   grant_id_q, grant_id_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tx_start_q, tx_start_d;
    logic               err_timeout_q, err_timeout_d;
    logic               active_q, active_d;

    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [DATA_W-1:0]  pick_byte;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .gnt_oh    (pick_oh),
        .gnt_idx   (pick_idx),
        .any       (pick_any)
    );

    // Offering ready only on the winner in IDLE means any offer is also a transfer.
    assign req_ready = (state_q == IDLE) ? pick_oh : '0;

    always_comb begin
        pick_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_byte = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_id_d    = grant_id_q;
        tx_data_d     = tx_data_q;
        cnt_d         = cnt_q;
        tx_start_d    = 1'b0;
        err_timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = ISSUE;
                    tx_data_d  = pick_byte;
                    grant_id_d = pick_idx;
                    ptr_d      = (pick_idx == IDX_W'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
                    // Registered so the pulse lines up with the ISSUE cycle.
                    tx_start_d = 1'b1;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // The error pulse was already launched a cycle earlier, so the abort
                // takes priority over a late tx_busy to keep pulse and abort paired.
                if (cnt_q == CNT_W'(START_TIMEOUT-1)) begin
                    state_d = IDLE;
                end else if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    // Pre-decoded one cycle early so err_timeout is high in the cycle
                    // where the counter reaches START_TIMEOUT-1.
                    if (cnt_q == CNT_W'(START_TIMEOUT-2)) begin
                        err_timeout_d = 1'b1;
                    end
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            grant_id_q    <= '0;
            tx_data_q     <= '0;
            cnt_q         <= '0;
            tx_start_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_id_q    <= grant_id_d;
            tx_data_q     <= tx_data_d;
            cnt_q         <= cnt_d;
            tx_start_q    <= tx_start_d;
            err_timeout_q <= err_timeout_d;
            active_q      <= active_d;
        end
    end

    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_id_q;
    assign active      = active_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Purpose: self-checking bench for uart_tx_arb with a transaction-level reference model.
// Latency: n/a.
// Backpressure: a simple transmitter model drives tx_busy for 10 cycles per start, or never.
module tb_uart_tx_arb;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int ST = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NR-1:0]  req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]  req_ready;
    logic           tx_start;
    logic [DW-1:0]  tx_data;
    logic           tx_busy;
    logic [1:0]     grant_id;
    logic           active;
    logic           err_timeout;

    uart_tx_arb #(.NUM_REQ(NR), .DATA_W(DW), .START_TIMEOUT(ST)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Transmitter model: busy for 10 cycles starting the cycle after tx_start, or never.
    bit xmode = 1'b1;
    int busy_left;
    initial begin
        tx_busy   = 1'b0;
        busy_left = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                busy_left = 0;
                tx_busy   = 1'b0;
            end else begin
                tx_busy = (busy_left > 0);
                if (busy_left > 0) busy_left--;
                if (tx_start && xmode) busy_left = 10;
            end
        end
    end

    // Reference model: idle flag, pointer, latched grant, and age in cycles since the accept.
    bit         m_idle = 1'b1;
    int         m_ptr  = 0;
    int         m_gid  = 0;
    logic [7:0] m_data = '0;
    int         m_age  = 0;
    bit         m_seen = 1'b0;

    int         gq[$];
    logic [7:0] dq[$];
    int         cyc = 0;
    int         start_cnt = 0;
    int         err_cnt = 0;
    int         t_start = 0;
    int         t_err = 0;
    bit         prev_start = 1'b0;
    bit         hold_v = 1'b0;
    logic [7:0] held = '0;

    function automatic int first_from(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    initial begin
        int w;
        logic [NR-1:0] exp_rdy;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_idle = 1'b1; m_ptr = 0; m_gid = 0; m_data = '0; m_age = 0; m_seen = 1'b0;
                prev_start = 1'b0; hold_v = 1'b0;
            end
            w       = first_from(req_valid, m_ptr);
            exp_rdy = (m_idle && w >= 0) ? NR'(1 << w) : '0;

            chk("req_ready",   req_ready,   exp_rdy);
            chk("tx_start",    tx_start,    !m_idle && m_age == 1);
            chk("err_timeout", err_timeout, !m_idle && !m_seen && m_age == ST + 1);
            chk("active",      active,      !m_idle);
            chk("grant_id",    grant_id,    m_gid);
            chk("tx_data",     tx_data,     m_data);
            chk("ptr",         dut.ptr_q,   m_ptr);

            chk("ready_onehot0", $onehot0(req_ready), 1);
            if (prev_start) chk("start_back2back", tx_start, 0);
            if (hold_v) begin
                if (!active) hold_v = 1'b0;
                else chk("tx_data_stable", tx_data, held);
            end
            if (tx_start) begin
                hold_v = 1'b1;
                held   = tx_data;
            end
            prev_start = tx_start;

            if (rst_n) begin
                for (int k = 0; k < NR; k++)
                    if (req_valid[k] && req_ready[k]) gq.push_back(k);
                if (tx_start) begin
                    start_cnt++; t_start = cyc; dq.push_back(tx_data);
                end
                if (err_timeout) begin
                    err_cnt++; t_err = cyc;
                end

                if (m_idle) begin
                    if (w >= 0) begin
                        m_idle = 1'b0; m_age = 1; m_seen = 1'b0;
                        m_gid  = w;
                        m_data = req_data[w*DW +: DW];
                        m_ptr  = (w + 1) % NR;
                    end
                end else if (m_age == 1) begin
                    m_age = 2;
                end else if (m_seen) begin
                    if (!tx_busy) m_idle = 1'b1;
                end else if (m_age == ST + 1) begin
                    m_idle = 1'b1;
                end else begin
                    if (tx_busy) m_seen = 1'b1;
                    m_age++;
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input int n0, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (gq.size() > n0) ok = 1'b1;
        end
        if (!ok) bound_fail(name);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (!active) ok = 1'b1;
        end
        if (!ok) bound_fail(name);
    endtask

    task automatic send(input logic [NR-1:0] mask, input string name);
        int n0;
        tick();
        n0 = gq.size();
        req_valid = mask;
        wait_accept(n0, name);
        tick();
        req_valid = '0;
        wait_idle(name);
    endtask

    initial begin
        int exp_g[6];
        logic [7:0] exp_d[6];
        int n0;
        int e0;
        int s0;
        bit ok;
        exp_g = '{0, 1, 2, 3, 0, 1};
        exp_d = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h40, 8'h41};

        // Reset with all requesters pending.
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_data  = {8'h43, 8'h42, 8'h41, 8'h40};
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_ready", req_ready, 4'b0001);
        @(negedge clk);
        chk("first_start", tx_start, 1);
        chk("first_data",  tx_data,  8'h40);

        // Round-robin fairness with continuous requests.
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (gq.size() >= 6) ok = 1'b1;
        end
        if (!ok) bound_fail("fair_wait");
        tick();
        req_valid = '0;
        wait_idle("fair_idle");
        for (int i = 0; i < 6; i++) begin
            chk("fair_grant", (i < gq.size()) ? gq[i] : -1, exp_g[i]);
            chk("fair_data",  (i < dq.size()) ? dq[i] : 8'hxx, exp_d[i]);
        end
        chk("fair_ptr", dut.ptr_q, 2);

        // Sparse requests and wrap.
        send(4'b0100, "sparse_2");
        chk("sparse_ptr3", dut.ptr_q, 3);
        send(4'b0010, "sparse_1");
        chk("sparse_g1",   grant_id,  1);
        chk("sparse_ptr2", dut.ptr_q, 2);
        send(4'b1000, "sparse_3");
        chk("sparse_g3",   grant_id,  3);
        chk("sparse_ptr0", dut.ptr_q, 0);

        // Start timeout: transmitter never raises busy.
        xmode = 1'b0;
        e0 = err_cnt;
        tick();
        req_valid = 4'b0011;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (err_cnt > e0) ok = 1'b1;
        end
        if (!ok) bound_fail("to_wait");
        chk("to_gap",   t_err - t_start, 16);
        chk("to_grant", grant_id, 0);
        n0 = gq.size();
        wait_accept(n0, "to_next");
        tick();
        req_valid = '0;
        chk("to_next_grant", gq[gq.size()-1], 1);
        wait_idle("to_idle");
        chk("to_err_count", err_cnt - e0, 2);
        xmode = 1'b1;

        // Reset in the middle of a frame.
        tick();
        n0 = gq.size();
        req_valid = 4'b0001;
        wait_accept(n0, "mid_accept");
        tick();
        req_valid = '0;
        repeat (4) tick();
        chk("mid_busy",   tx_busy, 1);
        chk("mid_active", active,  1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_start",  tx_start,    0);
        chk("mid_rst_active", active,      0);
        chk("mid_rst_err",    err_timeout, 0);
        chk("mid_rst_gid",    grant_id,    0);
        chk("mid_rst_data",   tx_data,     0);
        chk("mid_rst_ready",  req_ready,   0);
        chk("mid_rst_ptr",    dut.ptr_q,   0);
        repeat (2) tick();
        rst_n = 1'b1;
        s0 = start_cnt;
        repeat (20) tick();
        chk("mid_no_restart", start_cnt - s0, 0);
        n0 = gq.size();
        req_valid = 4'b0100;
        wait_accept(n0, "post_accept");
        tick();
        req_valid = '0;
        chk("post_grant", gq[gq.size()-1], 2);
        wait_idle("post_idle");
        chk("post_gid", grant_id, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
